ula_seq_exec: RTL and testbench

//  Sequential, handshaked ALU execution unit: responder side of the opcode/data1/data2 -> out/rflags interface.

---
 rtl/ula_seq_exec_if.sv | 40 ++++
 rtl/ula_seq_exec.sv | 181 ++++++++++++++++++
 tb/tb_ula_seq_exec.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/ula_seq_exec_if.sv
// Op-issue / result-return channel between the control unit (master) and ula_seq_exec (slave).
// The abort wire exists only when ULA_ABORT_EN is defined.
interface ula_seq_exec_if #(
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 4
);
  logic                           in_valid;
  logic                           in_ready;
  logic        [OPCODE_WIDTH-1:0] opcode;
  logic signed [DATA_WIDTH-1:0]   data1;
  logic signed [DATA_WIDTH-1:0]   data2;
  logic                           out_valid;
  logic                           out_ready;
  logic signed [DATA_WIDTH-1:0]   out;
  logic        [4:0]              rflags;

`ifdef ULA_ABORT_EN
  logic                           abort;

  modport master (
    output in_valid, opcode, data1, data2, out_ready, abort,
    input  in_ready, out_valid, out, rflags
  );

  modport slave (
    input  in_valid, opcode, data1, data2, out_ready, abort,
    output in_ready, out_valid, out, rflags
  );
`else
  modport master (
    output in_valid, opcode, data1, data2, out_ready,
    input  in_ready, out_valid, out, rflags
  );

  modport slave (
    input  in_valid, opcode, data1, data2, out_ready,
    output in_ready, out_valid, out, rflags
  );
`endif
endinterface

// File: rtl/ula_seq_exec.sv
// Handshaked sequential ALU: single-cycle ADD/SUB/AND/OR/NOT/CMP, iterative shift-add MUL and restoring DIV.
// Optional ULA_ABORT_EN adds an abort input that cancels an in-flight MUL/DIV.
module ula_seq_exec #(
  parameter int DATA_WIDTH   = 16,
  parameter int OPCODE_WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  ula_seq_exec_if.slave bus
);
  localparam int W     = DATA_WIDTH;
  localparam int CNT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_WIDTH - 1);

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] OP_SUB = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] OP_MUL = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] OP_DIV = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] OP_OR  = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOT = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] OP_CMP = OPCODE_WIDTH'(7);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_t;

  function automatic logic [W-1:0] f_mag(input logic signed [W-1:0] v);
    f_mag = v[W-1] ? $unsigned(-v) : $unsigned(v);
  endfunction

  // {OVERFLOW, ABOVE, EQUAL, BELOW, ERROR} derived from a signed result
  function automatic logic [4:0] f_flags(input logic [W-1:0] r, input logic ovf);
    f_flags = {ovf, ~r[W-1] & (|r), ~(|r), r[W-1], 1'b0};
  endfunction

  state_t             r_state, w_state_nxt;
  logic [CNT_W-1:0]   r_cnt;
  logic [W-1:0]       r_out;
  logic [4:0]         r_flags;
  logic               r_neg;
  logic [2*W-1:0]     r_acc, r_mcand;
  logic [W-1:0]       r_mplier, r_rem, r_quo, r_divisor;

  logic               w_accept, w_abort;
  logic [W-1:0]       w_mag_a, w_mag_b;
  logic signed [W-1:0] w_sum, w_dif;
  logic               w_ovf_add, w_ovf_sub;
  logic [W-1:0]       w_and, w_or, w_not;
  logic [W-1:0]       w_one_out;
  logic [4:0]         w_one_flags;
  logic [2*W-1:0]     w_acc_nxt, w_prod;
  logic               w_mul_ovf;
  logic [W:0]         w_shift;
  logic [W-1:0]       w_diff;
  logic               w_fits;
  logic [W-1:0]       w_div_res;
  logic               w_div_ovf;

`ifdef ULA_ABORT_EN
  assign w_abort = bus.abort;
`else
  assign w_abort = 1'b0;
`endif

  assign w_accept = bus.in_valid && bus.in_ready;
  assign w_mag_a  = f_mag(bus.data1);
  assign w_mag_b  = f_mag(bus.data2);

  assign w_sum     = bus.data1 + bus.data2;
  assign w_dif     = bus.data1 - bus.data2;
  assign w_ovf_add = (bus.data1[W-1] == bus.data2[W-1]) && (w_sum[W-1] != bus.data1[W-1]);
  assign w_ovf_sub = (bus.data1[W-1] != bus.data2[W-1]) && (w_dif[W-1] != bus.data1[W-1]);
  assign w_and     = bus.data1 & bus.data2;
  assign w_or      = bus.data1 | bus.data2;
  assign w_not     = ~bus.data1;

  // Default covers unknown opcodes and divide-by-zero: out=0, ERROR only
  always_comb begin
    w_one_out   = '0;
    w_one_flags = 5'b00001;
    case (bus.opcode)
      OP_ADD: begin w_one_out = w_sum; w_one_flags = f_flags(w_sum, w_ovf_add); end
      OP_SUB: begin w_one_out = w_dif; w_one_flags = f_flags(w_dif, w_ovf_sub); end
      OP_AND: begin w_one_out = w_and; w_one_flags = f_flags(w_and, 1'b0); end
      OP_OR:  begin w_one_out = w_or;  w_one_flags = f_flags(w_or, 1'b0); end
      OP_NOT: begin w_one_out = w_not; w_one_flags = f_flags(w_not, 1'b0); end
      OP_CMP: begin
        w_one_out   = '0;
        w_one_flags = {1'b0, bus.data1 > bus.data2, bus.data1 == bus.data2,
                       bus.data1 < bus.data2, 1'b0};
      end
      default: ;
    endcase
  end

  // Multiply: the final partial product is folded in combinationally on the last iteration
  assign w_acc_nxt = r_acc + (r_mplier[0] ? r_mcand : '0);
  assign w_prod    = r_neg ? -w_acc_nxt : w_acc_nxt;
  assign w_mul_ovf = (w_prod != {{W{w_prod[W-1]}}, w_prod[W-1:0]});

  // Restoring divide: partial remainder shifted with the next dividend bit from r_quo
  assign w_shift   = {r_rem, r_quo[W-1]};
  assign w_fits    = (w_shift >= {1'b0, r_divisor});
  assign w_diff    = w_shift[W-1:0] - r_divisor;
  assign w_div_res = r_neg ? -r_quo : r_quo;
  assign w_div_ovf = !r_neg && r_quo[W-1];

  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_neg     <= bus.data1[W-1] ^ bus.data2[W-1];
      r_acc     <= '0;
      r_mcand   <= {{W{1'b0}}, w_mag_a};
      r_mplier  <= w_mag_b;
      r_rem     <= '0;
      r_quo     <= w_mag_a;
      r_divisor <= w_mag_b;
    end else if (r_state == S_MUL) begin
      r_acc    <= w_acc_nxt;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
    end else if (r_state == S_DIV) begin
      r_rem <= w_fits ? w_diff : w_shift[W-1:0];
      r_quo <= {r_quo[W-2:0], w_fits};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_accept) begin
        if (bus.opcode == OP_MUL)                         w_state_nxt = S_MUL;
        else if (bus.opcode == OP_DIV && bus.data2 != '0) w_state_nxt = S_DIV;
        else                                              w_state_nxt = S_DONE;
      end
      S_MUL:  if (w_abort) w_state_nxt = S_IDLE;
              else if (r_cnt == CNT_LAST) w_state_nxt = S_DONE;
      S_DIV:  if (w_abort) w_state_nxt = S_IDLE;
              else if (r_cnt == CNT_LAST) w_state_nxt = S_FIX;
      S_FIX:  w_state_nxt = w_abort ? S_IDLE : S_DONE;
      S_DONE: if (bus.out_ready) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // in_ready is gated by rst_n so nothing is accepted while reset is held
  always_comb begin
    bus.in_ready  = (r_state == S_IDLE) && rst_n;
    bus.out_valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_out   <= '0;
      r_flags <= '0;
    end else begin
      if (w_accept)
        r_cnt <= '0;
      else if ((r_state == S_MUL || r_state == S_DIV) && !w_abort)
        r_cnt <= r_cnt + CNT_W'(1);

      if (w_accept && w_state_nxt == S_DONE) begin
        r_out   <= w_one_out;
        r_flags <= w_one_flags;
      end else if (r_state == S_MUL && r_cnt == CNT_LAST && !w_abort) begin
        r_out   <= w_prod[W-1:0];
        r_flags <= f_flags(w_prod[W-1:0], w_mul_ovf);
      end else if (r_state == S_FIX && !w_abort) begin
        r_out   <= w_div_res;
        r_flags <= f_flags(w_div_res, w_div_ovf);
      end
    end
  end

  assign bus.out    = r_out;
  assign bus.rflags = r_flags;
endmodule

// File: tb/tb_ula_seq_exec.sv
// Directed-vector bench for ula_seq_exec: hand-computed results, flags and latencies.
module tb_ula_seq_exec;
  localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_MUL = 4'd2, OP_DIV = 4'd3;
  localparam logic [3:0] OP_AND = 4'd4, OP_OR  = 4'd5, OP_NOT = 4'd6, OP_CMP = 4'd7;

  logic clk = 1'b0;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;

  ula_seq_exec_if #(.DATA_WIDTH(16), .OPCODE_WIDTH(4)) bus ();

  ula_seq_exec #(.DATA_WIDTH(16), .OPCODE_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    int guard = 0;
    @(negedge clk);
    while (!bus.in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk_vec({tag, "_inrdy"}, 32'(bus.in_ready), 32'd1);
    bus.opcode   = op;
    bus.data1    = a;
    bus.data2    = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_res(input string tag, input logic [15:0] e_out, input logic [4:0] e_fl, input int e_lat);
    int lat = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) break;
    end
    chk_vec({tag, "_lat"}, 32'(lat), 32'(e_lat));
    chk_vec({tag, "_out"}, 32'($unsigned(bus.out)), 32'(e_out));
    chk_vec({tag, "_fl"},  32'(bus.rflags), 32'(e_fl));
    chk_vec({tag, "_busy"}, 32'(bus.in_ready), 32'd0);
  endtask

  task automatic drain(input string tag);
    @(negedge clk);
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    chk_vec({tag, "_drain"}, 32'(bus.out_valid), 32'd0);
  endtask

  task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a, input logic [15:0] b,
                        input logic [15:0] e_out, input logic [4:0] e_fl, input int e_lat);
    issue(tag, op, a, b);
    wait_res(tag, e_out, e_fl, e_lat);
    drain(tag);
  endtask

  task automatic quiet(input string tag, input int cycles);
    int seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (bus.out_valid) seen++;
    end
    chk_vec({tag, "_quiet"}, 32'(seen), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL tb_timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.opcode    = '0;
    bus.data1     = '0;
    bus.data2     = '0;
`ifdef ULA_ABORT_EN
    bus.abort     = 1'b0;
`endif
    repeat (3) @(negedge clk);
    chk_vec("rst_inrdy", 32'(bus.in_ready), 32'd0);
    chk_vec("rst_ovld",  32'(bus.out_valid), 32'd0);
    chk_vec("rst_out",   32'($unsigned(bus.out)), 32'd0);
    chk_vec("rst_fl",    32'(bus.rflags), 32'd0);
    rst_n = 1'b1;
    #1;
    chk_vec("rel_inrdy", 32'(bus.in_ready), 32'd1);

    // ADD overflow with result held under back-pressure
    issue("add_ovf", OP_ADD, 16'h7FFF, 16'h0001);
    wait_res("add_ovf", 16'h8000, 5'b10010, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk_vec("hold_vld", 32'(bus.out_valid), 32'd1);
      chk_vec("hold_out", 32'($unsigned(bus.out)), 32'h8000);
      chk_vec("hold_fl",  32'(bus.rflags), 32'(5'b10010));
      chk_vec("hold_rdy", 32'(bus.in_ready), 32'd0);
    end
    drain("add_ovf");

    run_op("sub",      OP_SUB, 16'd5,     16'd7,     16'hFFFE, 5'b00010, 1);
    run_op("sub_ovf",  OP_SUB, 16'h8000,  16'd1,     16'h7FFF, 5'b11000, 1);
    run_op("mul_neg",  OP_MUL, 16'hFFFB,  16'd2,     16'hFFF6, 5'b00010, 17);
    run_op("mul_ovf",  OP_MUL, 16'h7FFF,  16'd2,     16'hFFFE, 5'b10010, 17);
    run_op("mul_nn",   OP_MUL, 16'hFFFD,  16'hFFFC,  16'd12,   5'b01000, 17);
    run_op("mul_zero", OP_MUL, 16'd0,     16'd123,   16'd0,    5'b00100, 17);
    run_op("div_neg",  OP_DIV, 16'hFFFB,  16'd2,     16'hFFFE, 5'b00010, 18);
    run_op("div_mix",  OP_DIV, 16'd100,   16'hFFF9,  16'hFFF2, 5'b00010, 18);
    run_op("div_zero", OP_DIV, 16'd6,     16'd0,     16'd0,    5'b00001, 1);
    run_op("div_ovf",  OP_DIV, 16'h8000,  16'hFFFF,  16'h8000, 5'b10010, 18);
    run_op("and",      OP_AND, 16'h0F0F,  16'h00FF,  16'h000F, 5'b01000, 1);
    run_op("or",       OP_OR,  16'h8000,  16'h0001,  16'h8001, 5'b00010, 1);
    run_op("cmp_gt",   OP_CMP, 16'd1,     16'h8000,  16'd0,    5'b01000, 1);
    run_op("cmp_eq",   OP_CMP, 16'd5,     16'd5,     16'd0,    5'b00100, 1);
    run_op("cmp_lt",   OP_CMP, 16'hFFFD,  16'd4,     16'd0,    5'b00010, 1);
    run_op("bad_op",   4'hF,   16'd9,     16'd9,     16'd0,    5'b00001, 1);
    run_op("not",      OP_NOT, 16'd0,     16'h1234,  16'hFFFF, 5'b00010, 1);

    // Reset in the middle of a divide discards it
    issue("rdiv", OP_DIV, 16'd7, 16'd2);
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk_vec("mrst_ovld",  32'(bus.out_valid), 32'd0);
    chk_vec("mrst_out",   32'($unsigned(bus.out)), 32'd0);
    chk_vec("mrst_fl",    32'(bus.rflags), 32'd0);
    chk_vec("mrst_inrdy", 32'(bus.in_ready), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_vec("mrel_inrdy", 32'(bus.in_ready), 32'd1);
    quiet("mrst", 20);
    run_op("div_7_2", OP_DIV, 16'd7, 16'd2, 16'd3, 5'b01000, 18);

`ifdef ULA_ABORT_EN
    issue("abt", OP_MUL, 16'd300, 16'd7);
    repeat (7) @(posedge clk);
    #1;
    bus.abort = 1'b1;
    @(posedge clk);
    #1;
    bus.abort = 1'b0;
    chk_vec("abt_inrdy", 32'(bus.in_ready), 32'd1);
    chk_vec("abt_ovld",  32'(bus.out_valid), 32'd0);
    chk_vec("abt_out",   32'($unsigned(bus.out)), 32'd3);
    chk_vec("abt_fl",    32'(bus.rflags), 32'(5'b01000));
    quiet("abt", 20);
    run_op("abt_add", OP_ADD, 16'd5, 16'd10, 16'd15, 5'b01000, 1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
